// File: rtl/temp_read_sched.sv
// temp_read_sched: periodic measurement scheduler for the SPI temperature
// sensor path.
//
// Counts toggles (either edge) of the timer output. Once every period_ticks
// toggles it issues a single read request to the SPI master. It then waits for
// completion, bounded by a timeout, and latches the returned sample.
//
// Handshake with the SPI master: spi_start_out is a one-cycle request. It is
// only issued when spi_busy_in is low. After a request, exactly one of two
// events ends the transaction: a one-cycle spi_done_in (with spi_data_in
// valid in the same cycle), or the internal timeout. No new request is
// issued before that happens.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous reset, active-high
//   enable_in       scheduler run enable
//   tick_in         timer toggle output (synchronous to clk_in)
//   clr_in          clears the sticky error flags
//   spi_busy_in     SPI master transaction in progress
//   spi_done_in     one-cycle read-complete pulse
//   spi_data_in     read data, valid with spi_done_in
//   spi_start_out   one-cycle read request
//   temp_out        last successful sample
//   temp_valid_out  one-cycle pulse when temp_out is updated
//   err_timeout_out sticky: the last read timed out
//   overrun_out     sticky: a tick arrived while a read was in flight
//   sample_cnt_out  count of successful reads (wraps)
module temp_read_sched #(
    parameter int unsigned period_ticks = 1,
    parameter int unsigned timeout_clks = 4096,
    parameter int unsigned data_w       = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic              tick_in,
    input  logic              clr_in,
    input  logic              spi_busy_in,
    input  logic              spi_done_in,
    input  logic [data_w-1:0] spi_data_in,
    output logic              spi_start_out,
    output logic [data_w-1:0] temp_out,
    output logic              temp_valid_out,
    output logic              err_timeout_out,
    output logic              overrun_out,
    output logic [7:0]        sample_cnt_out
);

    localparam logic [7:0]  TICK_LAST = 8'(period_ticks - 1);
    localparam logic [15:0] TO_LAST   = 16'(timeout_clks - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              tick_q;
    logic [7:0]        tick_cnt_q, tick_cnt_d;
    logic [15:0]       to_cnt_q, to_cnt_d;
    logic              start_q, start_d;
    logic [data_w-1:0] temp_q, temp_d;
    logic              valid_q, valid_d;
    logic              err_to_q, err_to_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        sample_cnt_q, sample_cnt_d;

    logic tick;
    logic read_end;

    // One tick per toggle of the timer output, either direction.
    assign tick = (tick_in != tick_q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            tick_q       <= 1'b0;
            tick_cnt_q   <= '0;
            to_cnt_q     <= '0;
            start_q      <= 1'b0;
            temp_q       <= '0;
            valid_q      <= 1'b0;
            err_to_q     <= 1'b0;
            overrun_q    <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_in;
            tick_cnt_q   <= tick_cnt_d;
            to_cnt_q     <= to_cnt_d;
            start_q      <= start_d;
            temp_q       <= temp_d;
            valid_q      <= valid_d;
            err_to_q     <= err_to_d;
            overrun_q    <= overrun_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        to_cnt_d     = to_cnt_q;
        start_d      = 1'b0;
        temp_d       = temp_q;
        valid_d      = 1'b0;
        err_to_d     = err_to_q;
        overrun_d    = overrun_q;
        sample_cnt_d = sample_cnt_q;
        read_end     = 1'b0;

        // Clear first so that any set below in the same cycle wins.
        if (clr_in) begin
            err_to_d  = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d    = ARM;
                    tick_cnt_d = '0;
                end
            end

            ARM: begin
                if (!enable_in) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end
            end

            START: begin
                // Ticks during a read are flagged but not counted; the
                // period restarts on return to ARM.
                if (tick) begin
                    overrun_d = 1'b1;
                end
                if (!spi_busy_in) begin
                    start_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                to_cnt_d = to_cnt_q + 16'd1;
                // Done is checked first so it wins over a same-cycle timeout.
                if (spi_done_in) begin
                    temp_d       = spi_data_in;
                    valid_d      = 1'b1;
                    sample_cnt_d = sample_cnt_q + 8'd1;
                    err_to_d     = 1'b0;
                    read_end     = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    read_end = 1'b1;
                end
                if (read_end) begin
                    tick_cnt_d = '0;
                    state_d    = enable_in ? ARM : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign spi_start_out   = start_q;
    assign temp_out        = temp_q;
    assign temp_valid_out  = valid_q;
    assign err_timeout_out = err_to_q;
    assign overrun_out     = overrun_q;
    assign sample_cnt_out  = sample_cnt_q;

endmodule

// File: doc/temp_read_sched.md
Name: temp_read_sched

Overview:
Periodic measurement scheduler for the SPI temperature-sensor path. Counts period edges from the timer block's toggling output. Every period_ticks periods it issues one read request to the SPI master, waits for completion with a timeout, and latches the 16-bit result. Sits between the timer and the SPI master. Provides the rest of the design with a registered sample, a valid strobe and sticky error flags.

Parameters:
period_ticks, 1, number of timer toggles (either edge) between reads; legal range 1..255
timeout_clks, 4096, max clk_in cycles in WAIT_DONE before abort; legal range 2..65535
data_w, 16, width of SPI read data and temp_out

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous reset, active-high
enable_in  in  1  scheduler run enable
tick_in  in  1  timer toggle output; synchronous to clk_in; resets low
clr_in  in  1  clears sticky flags
spi_busy_in  in  1  SPI master transaction in progress
spi_done_in  in  1  one-cycle pulse, read complete
spi_data_in  in  data_w  read data, valid with spi_done_in
spi_start_out  out  1  one-cycle read request
temp_out  out  data_w  last successful sample
temp_valid_out  out  1  one-cycle pulse, temp_out updated
err_timeout_out  out  1  sticky, last read timed out
overrun_out  out  1  sticky, tick arrived while a read was in flight
sample_cnt_out  out  8  count of successful reads, wraps

Behaviour:
- Reset (async, rst_in=1): state=IDLE. All outputs 0. tick_q=0, tick_cnt=0, to_cnt=0.
- Tick detect: tick = (tick_in != tick_q); tick_q <= tick_in every cycle. One tick per toggle, either edge.
- States: IDLE, ARM, START, WAIT_DONE.
- IDLE:
  - enable_in=1 -> ARM with tick_cnt=0.
  - Ticks are ignored.
- ARM:
  - enable_in=0 -> IDLE. Takes priority over a same-cycle tick.
  - On a tick with tick_cnt==period_ticks-1: go to START, tick_cnt=0.
  - On any other tick: tick_cnt+1.
- START:
  - If spi_busy_in=0: spi_start_out=1 for exactly the next cycle (registered), to_cnt=0, go to WAIT_DONE.
  - If spi_busy_in=1: hold in START with spi_start_out=0.
  - Latency: qualifying tick sampled at edge N with busy low -> spi_start_out high during cycle N+1 to N+2.
- WAIT_DONE:
  - to_cnt increments each cycle.
  - spi_done_in=1: temp_out<=spi_data_in; temp_valid_out=1 next cycle only; sample_cnt_out+1 (255->0); err_timeout_out<=0.
  - to_cnt==timeout_clks-1 with no done: err_timeout_out<=1, temp_out unchanged, no valid pulse.
  - Done and timeout in the same cycle: done wins.
  - Exit (either case): ARM with tick_cnt=0 if enable_in=1, else IDLE.
- enable_in=0 in START or WAIT_DONE does not abort. START still issues its request; WAIT_DONE completes or times out, then goes to IDLE.
- Overrun: a tick while in START or WAIT_DONE sets overrun_out. That tick is not counted; the period restarts on ARM entry.
- clr_in=1 clears err_timeout_out and overrun_out. A same-cycle set wins over clr.
- spi_start_out never asserts twice without an intervening done or timeout.
- Reset mid-read: immediate return to IDLE, outputs 0. A spi_done_in arriving after reset release is ignored (state is not WAIT_DONE).

Test Plan:
- period_ticks=3, enable=1, tick_in toggles every 10 clk, SPI returns done 5 clk after start with data 16'h0A5C -> one spi_start_out pulse per 3 toggles; temp_out=16'h0A5C; temp_valid_out 1 cycle; sample_cnt_out=1,2,3 over three periods.
- timeout_clks=8, no spi_done_in after start -> err_timeout_out=1 exactly 8 cycles after entering WAIT_DONE; no valid pulse; next read with done clears err_timeout_out.
- spi_busy_in held 1 for 20 clk when START is entered -> spi_start_out stays 0; pulses once, 1 cycle after busy falls.
- period_ticks=1, tick toggles every 4 clk, SPI done latency 10 clk -> overrun_out=1; clr_in pulse clears it; clr and set in the same cycle -> stays 1.
- enable_in dropped in WAIT_DONE, then done with 16'h1234 -> temp_out=16'h1234 with valid pulse; state IDLE; later ticks produce no start.
- rst_in asserted mid-WAIT_DONE, then done pulse after release -> all outputs 0; no valid; sample_cnt_out=0.
